multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
Processor-side initiator for the multdiv unit. It accepts a MULT/DIV op from the execute stage and drives the ctrl_MULT/ctrl_DIV start pulse. It holds both operands stable for the whole operation and stalls the pipeline until data_resultRDY. It then captures result and exception and issues a single-cycle write-back, redirecting to $rstatus on exception.

Parameters:
RSTATUS_REG, 30, register index written on exception
MULT_EXC_CODE, 4, value written to RSTATUS_REG on MULT exception
DIV_EXC_CODE, 5, value written to RSTATUS_REG on DIV exception
TIMEOUT, 40, max WAIT cycles before forced abort (1..255; internal wait counter is 8 bits)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
op_valid  in  1  execute stage presents an op
op_is_mult  in  1  op is MULT
op_is_div  in  1  op is DIV
op_a  in  32  operand A
op_b  in  32  operand B
op_rd  in  5  destination register
flush  in  1  synchronous abort of any in-flight op
ctrl_MULT  out  1  start pulse to multdiv
ctrl_DIV  out  1  start pulse to multdiv
data_operandA  out  32  operand A to multdiv, registered
data_operandB  out  32  operand B to multdiv, registered
data_result  in  32  multdiv result
data_exception  in  1  multdiv exception flag
data_resultRDY  in  1  multdiv result ready
stall  out  1  freeze upstream pipeline
wb_valid  out  1  write-back strobe, one cycle
wb_reg  out  5  write-back register
wb_data  out  32  write-back data
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset_n=0, async): state=IDLE. All outputs 0, including operand registers, wait counter and captured op type.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - An op is accepted when op_valid=1 and exactly one of op_is_mult/op_is_div is 1.
  - If both or neither is set, nothing happens and stall stays 0.
  - On accept: register op_a→data_operandA, op_b→data_operandB, op_rd, and op type. stall=1 combinationally in that same cycle. Next state=ISSUE.
- ISSUE (1 cycle):
  - Exactly one of ctrl_MULT/ctrl_DIV=1, per the latched type. stall=1.
  - data_resultRDY is ignored (it may be stale from the previous op). Wait counter is cleared.
  - Next state=WAIT.
- WAIT:
  - stall=1. The wait counter increments each cycle.
  - If data_resultRDY=1: capture data_result and data_exception. Next state=DONE.
  - Else if the counter reaches TIMEOUT: force the exception path and set timeout_err for the DONE cycle. Next state=DONE.
  - RDY has priority over timeout when both occur in the same cycle.
- DONE (1 cycle):
  - wb_valid=1 and stall=0.
  - No exception: wb_reg=latched op_rd, wb_data=captured result.
  - Exception or timeout: wb_reg=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE per op type, zero-extended.
  - op_valid is ignored in this cycle. Next state=IDLE, so back-to-back ops have a 1-cycle gap.
  - op_rd=0 with no exception still produces wb_valid=1 with wb_reg=0; the regfile discards it.
- data_operandA/B change only on accept in IDLE. They stay constant from ISSUE through DONE, because multdiv samples its operands every cycle.
- ctrl_MULT/ctrl_DIV are high only in ISSUE, never both, never longer than 1 cycle.
- wb_valid, wb_reg, wb_data and timeout_err are registered outputs, decoded from state/captured regs. They are 0 outside DONE.
- Flush (synchronous, highest priority):
  - In any state, next state=IDLE. No wb_valid is produced, and a RDY arriving later is ignored.
  - Flush in IDLE blocks accept that cycle; stall=0.
  - Flush during ISSUE does not suppress the pulse already driven. Multdiv is simply abandoned.
- Reset mid-operation: all outputs drop to 0 immediately (async), with no write-back.
- Latency: accept at cycle T, pulse at T+1, WAIT from T+2. RDY sampled at cycle N gives wb_valid at N+1.

Test Plan:
- MULT 7×6, op_rd=5; model asserts RDY with result 42 and exception 0 on the 16th WAIT cycle → ctrl_MULT=1 exactly one cycle (T+1); operands stay 7/6 throughout; stall=1 T..N; wb_valid=1 one cycle at N+1 with wb_reg=5, wb_data=42; stall=0 in that cycle.
- DIV 9/0, op_rd=3; model returns exception=1 → ctrl_DIV pulses once; wb_reg=30, wb_data=5; no write to r3.
- Stale RDY: data_resultRDY held 1 before and during ISSUE → not captured in ISSUE; captured on the first WAIT cycle; wb_valid at T+3.
- Timeout: MULT, RDY never asserted → after 40 WAIT cycles, wb_valid=1 with wb_reg=30, wb_data=4, timeout_err=1 for one cycle; back in IDLE next cycle.
- Flush on WAIT cycle 5, then RDY on cycle 10 → state IDLE after flush; stall=0; no wb_valid ever. Separately, reset_n=0 mid-WAIT → all outputs 0 within the same cycle.
- Illegal op (op_is_mult=op_is_div=1, op_valid=1) → no accept, no ctrl pulse, stall=0; a valid DIV presented next cycle is accepted normally.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multdiv unit: latches a MULT/DIV op, pulses the start
// strobe, stalls the pipeline until the result is ready (or the watchdog fires), then writes it back.
module multdiv_issue_ctrl #(
    parameter int RSTATUS_REG   = 30,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5,
    parameter int TIMEOUT       = 40
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic        op_is_mult,
    input  logic        op_is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  op_rd,
    input  logic        flush,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [4:0]  RSTATUS_IDX = 5'(RSTATUS_REG);
    localparam logic [31:0] MULT_EXC    = 32'(MULT_EXC_CODE);
    localparam logic [31:0] DIV_EXC     = 32'(DIV_EXC_CODE);
    localparam logic [7:0]  WAIT_LAST   = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [4:0]  rd_reg;
    logic        is_div_reg;
    logic        accept;
    logic [31:0] exc_word;

    // Flush in IDLE must block acceptance, so it also keeps stall low.
    assign accept   = (state_reg == IDLE) && op_valid && (op_is_mult ^ op_is_div) && !flush;
    assign stall    = accept || (state_reg == ISSUE) || (state_reg == WAIT);
    assign exc_word = is_div_reg ? DIV_EXC : MULT_EXC;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            rd_reg        <= '0;
            is_div_reg    <= 1'b0;
            data_operandA <= '0;
            data_operandB <= '0;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg        <= '0;
            wb_data       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            ctrl_MULT   <= 1'b0;
            ctrl_DIV    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            timeout_err <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            data_operandA <= op_a;
                            data_operandB <= op_b;
                            rd_reg        <= op_rd;
                            is_div_reg    <= op_is_div;
                            ctrl_MULT     <= op_is_mult;
                            ctrl_DIV      <= op_is_div;
                            state_reg     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        // RDY seen here may belong to the previous op, so it is not looked at.
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end
                    WAIT: begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        if (data_resultRDY) begin
                            wb_valid  <= 1'b1;
                            wb_reg    <= data_exception ? RSTATUS_IDX : rd_reg;
                            wb_data   <= data_exception ? exc_word : data_result;
                            state_reg <= DONE;
                        end else if (wait_cnt_reg == WAIT_LAST) begin
                            wb_valid    <= 1'b1;
                            wb_reg      <= RSTATUS_IDX;
                            wb_data     <= exc_word;
                            timeout_err <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomized bench for multdiv_issue_ctrl; each op's expected cycle trace is derived
// from its parameters (result delay, exception, flush point) rather than from the RTL's state.
module tb_multdiv_issue_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        op_valid, op_is_mult, op_is_div;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic        flush;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;
    logic        stall, wb_valid, timeout_err;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multdiv_issue_ctrl #(.RSTATUS_REG(30), .MULT_EXC_CODE(4), .DIV_EXC_CODE(5), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_is_mult(op_is_mult),
        .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .flush(flush),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .data_operandA(data_operandA),
        .data_operandB(data_operandB), .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {26'd0, ctrl_MULT, ctrl_DIV, stall, wb_valid, timeout_err, 1'b0}, 32'd0);
        check({tag, "_opa"}, data_operandA, 32'd0);
        check({tag, "_opb"}, data_operandB, 32'd0);
        check({tag, "_wbr"}, {27'd0, wb_reg}, 32'd0);
        check({tag, "_wbd"}, wb_data, 32'd0);
    endtask

    // One op: rdy_w = WAIT cycle carrying RDY (0 = never), flush_w = WAIT cycle carrying flush (0 = none).
    task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rdy_w, input bit exc,
                          input logic [31:0] res, input bit stale, input int flush_w);
        bit          timed_out, flushed, to_rstatus;
        int          endw, lastw;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        timed_out  = (rdy_w < 1) || (rdy_w > TIMEOUT);
        endw       = timed_out ? TIMEOUT : rdy_w;
        flushed    = (flush_w >= 1) && (flush_w <= endw);
        to_rstatus = timed_out || exc;
        exp_reg    = to_rstatus ? 5'd30 : rd;
        exp_data   = to_rstatus ? (is_mult ? 32'd4 : 32'd5) : res;
        lastw      = flushed ? flush_w : endw;

        @(negedge clock);
        op_valid = 1'b1; op_is_mult = is_mult; op_is_div = !is_mult;
        op_a = a; op_b = b; op_rd = rd; flush = 1'b0;
        data_resultRDY = stale; data_result = res; data_exception = exc;
        #1;
        check("accept_stall", {31'd0, stall}, 32'd1);
        check("accept_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);

        @(negedge clock);
        op_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_rd = 5'($urandom);
        data_resultRDY = stale;
        #1;
        check("issue_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, {30'd0, is_mult, !is_mult});
        check("issue_stall", {31'd0, stall}, 32'd1);
        check("issue_opa", data_operandA, a);
        check("issue_opb", data_operandB, b);
        check("issue_wb", {31'd0, wb_valid}, 32'd0);

        for (int w = 1; w <= lastw; w++) begin
            @(negedge clock);
            data_resultRDY = (w == rdy_w);
            flush = (w == flush_w);
            #1;
            check("wait_ctl", {28'd0, ctrl_MULT, ctrl_DIV, stall, wb_valid}, 32'd2);
            check("wait_opa", data_operandA, a);
            check("wait_opb", data_operandB, b);
        end

        if (flushed) begin
            for (int w = flush_w + 1; w <= flush_w + 8; w++) begin
                @(negedge clock);
                flush = 1'b0;
                data_resultRDY = (w == rdy_w);
                #1;
                check("flushed_ctl", {27'd0, ctrl_MULT, ctrl_DIV, stall, wb_valid, timeout_err}, 32'd0);
            end
            data_resultRDY = 1'b0;
            $display("op %s a=%0h b=%0h rd=%0d flushed at wait %0d", is_mult ? "MULT" : "DIV", a, b, rd, flush_w);
        end else begin
            @(negedge clock);
            data_resultRDY = 1'b0; flush = 1'b0;
            op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b0;
            #1;
            check("done_wbv", {31'd0, wb_valid}, 32'd1);
            check("done_wbr", {27'd0, wb_reg}, {27'd0, exp_reg});
            check("done_wbd", wb_data, exp_data);
            check("done_tmo", {31'd0, timeout_err}, {31'd0, timed_out});
            check("done_stall", {31'd0, stall}, 32'd0);
            check("done_opa", data_operandA, a);
            @(negedge clock);
            op_valid = 1'b0;
            #1;
            check("post_ctl", {27'd0, ctrl_MULT, ctrl_DIV, stall, wb_valid, timeout_err}, 32'd0);
            $display("op %s a=%0h b=%0h rd=%0d waits=%0d exc=%0d timeout=%0d -> wb r%0d=%0h",
                     is_mult ? "MULT" : "DIV", a, b, rd, endw, exc, timed_out, exp_reg, exp_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset_n = 1'b0; op_valid = 1'b0; op_is_mult = 1'b0; op_is_div = 1'b0;
        op_a = '0; op_b = '0; op_rd = '0; flush = 1'b0;
        data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        run_op(1'b1, 32'd7, 32'd6, 5'd5, 16, 1'b0, 32'd42, 1'b0, 0);
        run_op(1'b0, 32'd9, 32'd0, 5'd3, 4, 1'b1, 32'hdead, 1'b0, 0);
        run_op(1'b1, 32'h1234, 32'h55, 5'd9, 1, 1'b0, 32'hbeef, 1'b1, 0);
        run_op(1'b1, 32'd11, 32'd13, 5'd7, 0, 1'b0, 32'd143, 1'b0, 0);
        run_op(1'b0, 32'd100, 32'd7, 5'd12, 10, 1'b0, 32'd14, 1'b0, 5);
        run_op(1'b0, 32'd8, 32'd2, 5'd0, 40, 1'b0, 32'd4, 1'b0, 0);

        // Illegal op, then a flush-blocked op, then a legal DIV.
        @(negedge clock);
        op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b1; op_a = 32'd77;
        #1 check("illegal_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        op_is_div = 1'b0; flush = 1'b1;
        #1 check("illegal_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        check("flushidle_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        op_valid = 1'b0; flush = 1'b0;
        #1 check("flushidle_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        $display("illegal op and flush-in-idle rejected");
        run_op(1'b0, 32'd21, 32'd3, 5'd17, 3, 1'b0, 32'd7, 1'b0, 0);

        // Async reset in the middle of WAIT.
        @(negedge clock);
        op_valid = 1'b1; op_is_mult = 1'b1; op_is_div = 1'b0; op_a = 32'hff; op_b = 32'h3; op_rd = 5'd4;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (4) @(negedge clock);
        data_resultRDY = 1'b1; data_result = 32'h2fd;
        reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clock);
        #1 check_all_zero("midreset_hold");
        data_resultRDY = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        #1 check("postreset_wb", {31'd0, wb_valid}, 32'd0);
        $display("reset mid-WAIT cleared outputs");

        for (int i = 0; i < 25; i++) begin
            bit st;
            int rw, fw;
            st = ($urandom_range(0, 4) == 0);
            rw = st ? 1 : $urandom_range(1, 50);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 0;
            run_op(1'($urandom), $urandom, $urandom, 5'($urandom), rw, 1'($urandom_range(0, 3) == 0),
                   $urandom, st, fw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
